// File: rtl/fsm_gen_pkg.sv
// ---------------------------------------------------------------------------
// fsm_gen_pkg
// Shared types and constants for the sequence-generator slice.
//   seq_state_t : generator FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   HIT_W       : width of the optional detector hit counter
// ---------------------------------------------------------------------------
package fsm_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } seq_state_t;

  localparam int HIT_W = 8;

endpackage

// File: rtl/fsm_seq_gen_if.sv
// ---------------------------------------------------------------------------
// fsm_seq_gen_if
// Request/stream bundle between a requester and fsm_seq_gen.
//   start, pattern, len, reps : request, driven by the master
//   x, valid, busy, done      : serial stream and status, driven by the generator
// Modports: master (requester side), slave (generator side).
// ---------------------------------------------------------------------------
interface fsm_seq_gen_if #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output x, valid, busy, done
  );

endinterface

// File: rtl/fsm_hit_counter.sv
// ---------------------------------------------------------------------------
// fsm_hit_counter
// Saturating event counter for detector hits. Present only when
// FSM_SEQ_GEN_HIT_CNT_EN is defined.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : synchronous clear (wins over inc_i)
//   inc_i      : count one event this cycle
//   cnt_o      : current count, saturates at all-ones
// ---------------------------------------------------------------------------
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
module fsm_hit_counter
  import fsm_gen_pkg::*;
#(
  parameter int W = HIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fsm_seq_gen.sv
// ---------------------------------------------------------------------------
// fsm_seq_gen
// Serial stimulus generator: captures a pattern of up to PAT_W bits and
// shifts pattern[len-1:0] out MSB-first on x, repeated reps extra times with
// no gap, followed by a one-cycle done pulse. All outputs are registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fsm_seq_gen_if.slave (start/pattern/len/reps in,
//                x/valid/busy/done out)
// Optional feature macro FSM_SEQ_GEN_HIT_CNT_EN adds:
//   y       : detector output, counted while busy
//   hit_cnt : saturating count of y, cleared on accepted start
// ---------------------------------------------------------------------------
module fsm_seq_gen
  import fsm_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  fsm_seq_gen_if.slave     bus
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
  ,
  input  logic             y,
  output logic [HIT_W-1:0] hit_cnt
`endif
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [IDX_W-1:0] last_q,  last_d;   // index of the first (MSB) bit sent
  logic [IDX_W-1:0] idx_q,   idx_d;    // index of the bit currently on x
  logic [REP_W-1:0] rep_q,   rep_d;
  logic             x_q,     x_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Length clamp at capture: 0 sends one bit, oversize sends PAT_W bits.
  logic [LEN_W-1:0] len_clamped;
  logic [IDX_W-1:0] start_idx;

  always_comb begin
    len_clamped = bus.len;
    if (bus.len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (bus.len > LEN_W'(PAT_W)) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  assign start_idx = IDX_W'(len_clamped - LEN_W'(1));

  // Outputs are computed one cycle ahead so x/valid/busy/done come straight
  // from flops; x_d therefore indexes with the *next* bit index.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    last_d  = last_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          pat_d   = bus.pattern;
          last_d  = start_idx;
          idx_d   = start_idx;
          rep_d   = bus.reps;
          x_d     = bus.pattern[start_idx];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d   = idx_q - IDX_W'(1);
          x_d     = pat_q[idx_d];
          valid_d = 1'b1;
        end else if (rep_q != '0) begin
          // Wrap straight into the next repetition, no idle cycle.
          idx_d   = last_q;
          rep_d   = rep_q - REP_W'(1);
          x_d     = pat_q[idx_d];
          valid_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the captured pattern is reset along with the counters; it is
      // only a PAT_W-bit register, and a clean zero state keeps x defined.
      state_q <= S_IDLE;
      pat_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef FSM_SEQ_GEN_HIT_CNT_EN
  logic accept;
  assign accept = (state_q == S_IDLE) && bus.start;

  fsm_hit_counter #(
    .W (HIT_W)
  ) u_hit_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept),
    .inc_i   (y && busy_q),
    .cnt_o   (hit_cnt)
  );
`endif

endmodule

// File: tb/tb_fsm_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_fsm_seq_gen
// Self-checking bench for fsm_seq_gen: a queue-based reference model expands
// each accepted request into its per-cycle output sequence; one compare
// process checks the DUT against it every cycle, and directed sends pin the
// model against hand-derived bit sequences.
// ---------------------------------------------------------------------------
module tb_fsm_seq_gen;
  import fsm_gen_pkg::*;

  localparam int PAT_W = 8;
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
  localparam int REP_W = 6;
`else
  localparam int REP_W = 4;
`endif
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic clk = 1'b0;
  logic reset;

  fsm_seq_gen_if #(.PAT_W(PAT_W), .REP_W(REP_W)) bus ();

`ifdef FSM_SEQ_GEN_HIT_CNT_EN
  logic             y;
  logic [HIT_W-1:0] hit_cnt;
`endif

  fsm_seq_gen #(
    .PAT_W (PAT_W),
    .REP_W (REP_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus)
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
    ,
    .y       (y),
    .hit_cnt (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- counters and checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic x;
    logic valid;
    logic busy;
    logic done;
  } out_t;

  out_t exp_q[$];
  out_t cur;
  bit   armed;
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
  int   exp_hit;
`endif

  // Expand one request into the full per-cycle output sequence.
  task automatic build(input logic [PAT_W-1:0] pat, input int len, input int reps);
    int n;
    n = (len == 0) ? 1 : (len > PAT_W) ? PAT_W : len;
    for (int r = 0; r <= reps; r++)
      for (int i = n - 1; i >= 0; i--)
        exp_q.push_back('{x: pat[i], valid: 1'b1, busy: 1'b1, done: 1'b0});
    exp_q.push_back('{x: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1});
  endtask

  initial begin
    bit acc;
    cur   = '0;
    armed = 1'b0;
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
    exp_hit = 0;
`endif
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        armed = 1'b1;
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
        exp_hit = 0;
`endif
      end else begin
        // A request is taken only when the previous cycle showed not busy.
        acc = bus.start && !cur.busy;
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
        if (acc) exp_hit = 0;
        else if (y && cur.busy && exp_hit < 255) exp_hit++;
`endif
        if (acc) build(bus.pattern, int'(bus.len), int'(bus.reps));
      end
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("model_outs", {bus.x, bus.valid, bus.busy, bus.done}, cur);
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
        check("model_hit", hit_cnt, exp_hit);
`endif
      end
    end
  end

  // ---------------- directed send with literal expectations ----------------
  // bits holds the n expected x values MSB-first; poke > 0 pulses start with
  // a different pattern during cycle poke of the send.
  task automatic send(input logic [PAT_W-1:0] pat, input int len, input int reps,
                      input logic [31:0] bits, input int n, input int poke);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = LEN_W'(len);
    bus.reps    = REP_W'(reps);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.pattern = ~pat;
    bus.len     = LEN_W'(1);
    bus.reps    = '0;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k <= n) begin
        check("lit_bit", {bus.x, bus.valid, bus.busy, bus.done}, {bits[n-k], 3'b110});
        check("lit_model_bit", cur.x, bits[n-k]);
      end else if (k == n + 1) begin
        check("lit_done", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0011);
      end else begin
        check("lit_idle", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
      end
      if (k == poke) begin
        bus.start   = 1'b1;
        bus.pattern = 8'h3C;
        bus.len     = LEN_W'(8);
      end else if (k == poke + 1) begin
        bus.start = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
    y = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;

    send(8'h03, 4, 0, 32'b0011, 4, 0);            // basic send
    send(8'h05, 3, 2, 32'b101101101, 9, 0);       // repeats, no gaps
    send(8'h01, 0, 0, 32'b1, 1, 0);               // len 0 -> 1 bit
    send(8'hA5, 15, 0, 32'b10100101, 8, 0);       // len clamped to 8
    send(8'hC3, 8, 0, 32'b11000011, 8, 3);        // start while busy ignored

    // Reset mid-operation: aborted, no done pulse, then a clean resend.
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.len     = LEN_W'(8);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    check("reset_no_done", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    send(8'h03, 4, 0, 32'b0011, 4, 0);

`ifdef FSM_SEQ_GEN_HIT_CNT_EN
    // Three hits while busy.
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.pattern = 8'h5A;
    bus.len     = LEN_W'(8);
    bus.reps    = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    y         = 1'b1;
    repeat (3) @(posedge clk);
    #1 y = 1'b0;
    repeat (12) @(negedge clk);
    check("hit_three", hit_cnt, 32'd3);

    // Long send with y held high saturates the count.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = LEN_W'(8);
    bus.reps  = REP_W'(63);
    y         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.reps  = '0;
    repeat (520) @(negedge clk);
    check("hit_saturate", hit_cnt, 32'd255);
    #1 y = 1'b0;
`endif

    // Randomized traffic, including starts at arbitrary times and rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset       = ($urandom_range(0, 199) == 0);
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.pattern = PAT_W'($urandom);
      bus.len     = LEN_W'($urandom_range(0, 15));
      bus.reps    = REP_W'($urandom_range(0, 3));
`ifdef FSM_SEQ_GEN_HIT_CNT_EN
      y = 1'($urandom);
`endif
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
